// File: rtl/i2c_reg_access.sv
// Register read/write sequencer driving an I2C byte master; one command in flight, one response out.
// Define I2C_REG16_EN for a 16-bit register pointer (adds the PTR_HI beat); default is an 8-bit pointer.
module i2c_reg_access #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdRead,
  input  logic [6:0]  cmdDev,
  input  logic [15:0] cmdReg,
  input  logic [7:0]  cmdWdata,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [7:0]  rspData,
  output logic        rspErr,
  output logic [6:0]  i2cAddr,
  output logic        i2cRdWr,
  output logic [7:0]  i2cInData,
  output logic        i2cInValid,
  input  logic        i2cInReady,
  input  logic [7:0]  i2cOutData,
  input  logic        i2cOutValid,
  output logic        i2cOutReady
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

`ifdef I2C_REG16_EN
  typedef enum logic [2:0] {IDLE, PTR_HI, PTR_LO, WDATA, GAP, RD_REQ, RD_WAIT, RESP} state_t;
  localparam int RW = 16;
`else
  typedef enum logic [2:0] {IDLE, PTR_LO, WDATA, GAP, RD_REQ, RD_WAIT, RESP} state_t;
  localparam int RW = 8;
  logic unused_reg_hi;
  assign unused_reg_hi = ^cmdReg[15:8];
`endif

  state_t          state_q, state_d;
  logic            read_q, read_d;
  logic [6:0]      dev_q, dev_d;
  logic [RW-1:0]   reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            in_valid, out_ready, in_hs;
  logic [7:0]      in_data;

  // Master-facing strobes decode from the state register only, so they are glitch-free.
  always_comb begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    case (state_q)
`ifdef I2C_REG16_EN
      PTR_HI:  begin in_valid = 1'b1; in_data = reg_q[15:8]; end
`endif
      PTR_LO:  begin in_valid = 1'b1; in_data = reg_q[7:0]; end
      WDATA:   begin in_valid = 1'b1; in_data = wdata_q; end
      RD_REQ:  begin in_valid = 1'b1; in_data = 8'h01; end
      RD_WAIT: out_ready = 1'b1;
      default: ;
    endcase
  end

  assign in_hs = in_valid & i2cInReady;

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = '0;
    case (state_q)
      IDLE: if (cmdValid && cmd_ready_q) begin
        read_d  = cmdRead;
        dev_d   = cmdDev;
        reg_d   = cmdReg[RW-1:0];
        wdata_d = cmdWdata;
        err_d   = 1'b0;
`ifdef I2C_REG16_EN
        state_d = PTR_HI;
`else
        state_d = PTR_LO;
`endif
      end
`ifdef I2C_REG16_EN
      PTR_HI:  if (in_hs) state_d = PTR_LO;
`endif
      PTR_LO:  if (in_hs) state_d = read_q ? GAP : WDATA;
      WDATA:   if (in_hs) begin state_d = RESP; rdata_d = 8'h00; end
      GAP:     state_d = RD_REQ;
      RD_REQ:  if (in_hs) state_d = RD_WAIT;
      RD_WAIT: if (i2cOutValid) begin state_d = RESP; rdata_d = i2cOutData; end
      RESP:    if (rspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Stall watchdog: only counts while a handshake is pending and unanswered.
    if ((in_valid || out_ready) && state_d == state_q) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_d == TMO_MAX) begin
        state_d = RESP;
        rdata_d = 8'hFF;
        err_d   = 1'b1;
        tmo_d   = '0;
      end
    end
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      read_q      <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmdReady    = cmd_ready_q;
  assign rspValid    = (state_q == RESP);
  assign rspData     = rdata_q;
  assign rspErr      = err_q;
  assign i2cAddr     = dev_q;
  assign i2cRdWr     = (state_q == RD_REQ) || (state_q == RD_WAIT);
  assign i2cInData   = in_data;
  assign i2cInValid  = in_valid;
  assign i2cOutReady = out_ready;

endmodule

// File: tb/tb_i2c_reg_access.sv
// Scoreboard bench for i2c_reg_access: a forked master/consumer model checks beats and responses.
module tb_i2c_reg_access;
  localparam int TMO = 16;
`ifdef I2C_REG16_EN
  localparam int NPTR = 2;
`else
  localparam int NPTR = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        cmdValid, cmdReady, cmdRead;
  logic [6:0]  cmdDev;
  logic [15:0] cmdReg;
  logic [7:0]  cmdWdata;
  logic        rspValid, rspReady, rspErr;
  logic [7:0]  rspData;
  logic [6:0]  i2cAddr;
  logic        i2cRdWr, i2cInValid, i2cInReady, i2cOutValid, i2cOutReady;
  logic [7:0]  i2cInData, i2cOutData;

  i2c_reg_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdRead(cmdRead), .cmdDev(cmdDev),
    .cmdReg(cmdReg), .cmdWdata(cmdWdata),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
    .i2cAddr(i2cAddr), .i2cRdWr(i2cRdWr), .i2cInData(i2cInData), .i2cInValid(i2cInValid),
    .i2cInReady(i2cInReady), .i2cOutData(i2cOutData), .i2cOutValid(i2cOutValid),
    .i2cOutReady(i2cOutReady)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [6:0] addr; logic rdwr; logic [7:0] data; } beat_t;
  typedef struct packed { logic err; logic [7:0] data; } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int rsp_count = 0;
  int in_stall = 0;
  logic [7:0] stall_data = 8'h00;
  int rsp_hold = 0;
  bit out_never = 1'b0;
  logic [7:0] out_byte = 8'h00;
  int out_lat = 2;

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic push_cmd(input bit rd, input logic [6:0] dev, input logic [15:0] rg,
                          input logic [7:0] wd, input logic [7:0] rdata);
`ifdef I2C_REG16_EN
    beat_q.push_back({dev, 1'b0, rg[15:8]});
`endif
    beat_q.push_back({dev, 1'b0, rg[7:0]});
    if (rd) begin
      beat_q.push_back({dev, 1'b1, 8'h01});
      rsp_q.push_back({1'b0, rdata});
    end else begin
      beat_q.push_back({dev, 1'b0, wd});
      rsp_q.push_back({1'b0, 8'h00});
    end
  endtask

  // Returns in the acceptance cycle with cmdValid still high.
  task automatic send(input bit rd, input logic [6:0] dev, input logic [15:0] rg, input logic [7:0] wd);
    int n;
    cmdRead = rd; cmdDev = dev; cmdReg = rg; cmdWdata = wd; cmdValid = 1'b1;
    n = 0;
    while (!cmdReady && n < 200) begin tick(); n++; end
    if (!cmdReady) begin
      vectors++; miscompares++;
      $display("FAIL accept_wait: cmdReady=%0b required 1 within 200 cycles", cmdReady);
    end
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_count < target && n < 300) begin tick(); n++; end
    vectors++;
    if (rsp_count < target) begin
      miscompares++;
      $display("FAIL rsp_wait: responses=%0d required %0d", rsp_count, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      tick();
      vectors++;
      if ({cmdReady, rspValid, rspData, rspErr, i2cAddr, i2cRdWr, i2cInData, i2cInValid, i2cOutReady} !== 29'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: cmdReady=%0b rspValid=%0b rspData=%h inValid=%0b required all 0",
                 cmdReady, rspValid, rspData, i2cInValid);
      end
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (cmdReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: cmdReady=%0b required 1", cmdReady);
    end
  endtask

  task automatic test_write();
    int cnt;
    int tgt;
    tgt = rsp_count + 1;
    push_cmd(1'b0, 7'h50, 16'h0012, 8'hA5, 8'h00);
    send(1'b0, 7'h50, 16'h0012, 8'hA5);
    cnt = 0;
    do begin tick(); cmdValid = 1'b0; cnt++; end while (!rspValid && cnt < 50);
    vectors++;
    if (cnt !== NPTR + 2) begin
      miscompares++;
      $display("FAIL write_latency: cycles=%0d required %0d", cnt, NPTR + 2);
    end
    wait_rsp(tgt);
  endtask

  task automatic test_read();
    int tgt;
    tgt = rsp_count + 1;
    out_byte = 8'h3C; out_lat = 2;
    push_cmd(1'b1, 7'h48, 16'h1234, 8'h00, 8'h3C);
    send(1'b1, 7'h48, 16'h1234, 8'h77);
    tick(); cmdValid = 1'b0;
    wait_rsp(tgt);
  endtask

  task automatic test_stall();
    int tgt;
    tgt = rsp_count + 1;
    stall_data = 8'h77; in_stall = 5;
    push_cmd(1'b0, 7'h21, 16'h1177, 8'h99, 8'h00);
    send(1'b0, 7'h21, 16'h1177, 8'h99);
    tick(); cmdValid = 1'b0;
    wait_rsp(tgt);
    vectors++;
    if (in_stall !== 0) begin
      miscompares++;
      $display("FAIL stall_consumed: stall cycles left=%0d required 0", in_stall);
    end
  endtask

  task automatic test_back_to_back();
    int held, n, tgt;
    tgt = rsp_count + 2;
    rsp_hold = 10; out_byte = 8'h81; out_lat = 0;
    push_cmd(1'b0, 7'h2A, 16'h0005, 8'h5A, 8'h00);
    send(1'b0, 7'h2A, 16'h0005, 8'h5A);
    tick();
    // Next command waits on the bus the whole time; it must only be taken after the handshake.
    push_cmd(1'b1, 7'h2B, 16'h0066, 8'h00, 8'h81);
    cmdRead = 1'b1; cmdDev = 7'h2B; cmdReg = 16'h0066; cmdWdata = 8'h00;
    held = 0; n = 0;
    while (!(rspValid && rspReady) && n < 100) begin
      vectors++;
      if (cmdReady !== 1'b0 || (rspValid && rspData !== 8'h00)) begin
        miscompares++;
        $display("FAIL hold_busy: cmdReady=%0b rspData=%h required 0/00", cmdReady, rspData);
      end
      if (rspValid) held++;
      tick(); n++;
    end
    vectors++;
    if (held !== 10) begin
      miscompares++;
      $display("FAIL hold_cycles: held=%0d required 10", held);
    end
    tick();
    vectors++;
    if (cmdReady !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: cmdReady=%0b required 1", cmdReady);
    end
    tick(); cmdValid = 1'b0;
    wait_rsp(tgt);
  endtask

  task automatic test_timeout();
    int n, stalled, tgt;
    tgt = rsp_count + 1;
    out_never = 1'b1;
    push_cmd(1'b1, 7'h11, 16'h0042, 8'h00, 8'h00);
    void'(rsp_q.pop_back());
    rsp_q.push_back({1'b1, 8'hFF});
    send(1'b1, 7'h11, 16'h0042, 8'h00);
    tick(); cmdValid = 1'b0;
    n = 0; stalled = 0;
    while (!rspValid && n < 200) begin
      if (i2cOutReady) stalled++;
      tick(); n++;
    end
    vectors++;
    if (stalled !== TMO) begin
      miscompares++;
      $display("FAIL timeout_cycles: stalled=%0d required %0d", stalled, TMO);
    end
    vectors++;
    if (i2cOutReady !== 1'b0 || i2cInValid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_release: outReady=%0b inValid=%0b required 0/0", i2cOutReady, i2cInValid);
    end
    wait_rsp(tgt);
    out_never = 1'b0;
  endtask

  task automatic test_midreset();
    int n, tgt;
    stall_data = 8'hC3; in_stall = 1000;
    push_cmd(1'b0, 7'h33, 16'h0044, 8'hC3, 8'h00);
    send(1'b0, 7'h33, 16'h0044, 8'hC3);
    tick(); cmdValid = 1'b0;
    n = 0;
    while (!(i2cInValid && i2cInData == 8'hC3) && n < 50) begin tick(); n++; end
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({cmdReady, rspValid, rspData, rspErr, i2cAddr, i2cRdWr, i2cInData, i2cInValid, i2cOutReady} !== 29'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: inValid=%0b inData=%h rspData=%h cmdReady=%0b required all 0",
               i2cInValid, i2cInData, rspData, cmdReady);
    end
    beat_q.delete(); rsp_q.delete(); in_stall = 0;
    reset = 1'b1;
    tick();
    tgt = rsp_count + 1;
    push_cmd(1'b0, 7'h34, 16'h0045, 8'h3E, 8'h00);
    send(1'b0, 7'h34, 16'h0045, 8'h3E);
    tick(); cmdValid = 1'b0;
    wait_rsp(tgt);
    repeat (5) tick();
    vectors++;
    if (rsp_count !== tgt) begin
      miscompares++;
      $display("FAIL midreset_rsp_count: responses=%0d required %0d", rsp_count, tgt);
    end
  endtask

  initial begin
    reset = 1'b0; cmdValid = 1'b0; cmdRead = 1'b0; cmdDev = '0; cmdReg = '0; cmdWdata = '0;
    rspReady = 1'b0; i2cInReady = 1'b0; i2cOutValid = 1'b0; i2cOutData = 8'h00;
    fork
      begin : master_model
        logic prev_stall, prev_valid, prev_rdwr;
        logic [7:0] prev_data;
        int out_cnt;
        beat_t b;
        rsp_t r;
        prev_stall = 1'b0; prev_valid = 1'b0; prev_rdwr = 1'b0; prev_data = 8'h00; out_cnt = 0;
        forever begin
          @(negedge clock);
          i2cInReady = !(i2cInValid && i2cInData == stall_data && in_stall > 0);
          if (i2cInValid && !i2cInReady) in_stall--;
          if (prev_stall && i2cInValid) begin
            vectors++;
            if (i2cInData !== prev_data) begin
              miscompares++;
              $display("FAIL stall_data_stable: inData=%h required %h", i2cInData, prev_data);
            end
          end
          if (prev_valid && i2cInValid) begin
            vectors++;
            if (i2cRdWr !== prev_rdwr) begin
              miscompares++;
              $display("FAIL transfer_gap: rdWr=%0b changed with no idle cycle, required %0b", i2cRdWr, prev_rdwr);
            end
          end
          prev_stall = i2cInValid && !i2cInReady;
          prev_data  = i2cInData;
          prev_valid = i2cInValid;
          prev_rdwr  = i2cRdWr;
          // Outside RD_WAIT the master babbles junk; the sequencer must ignore it.
          if (i2cOutReady) begin
            if (out_never) i2cOutValid = 1'b0;
            else if (out_cnt >= out_lat) begin i2cOutValid = 1'b1; i2cOutData = out_byte; end
            else begin i2cOutValid = 1'b0; out_cnt++; end
          end else begin
            i2cOutValid = 1'b1; i2cOutData = 8'hEE; out_cnt = 0;
          end
          if (i2cInValid && i2cInReady) begin
            vectors++;
            if (beat_q.size() == 0) begin
              miscompares++;
              $display("FAIL beat_unexpected: addr=%h rdWr=%0b data=%h required none", i2cAddr, i2cRdWr, i2cInData);
            end else begin
              b = beat_q.pop_front();
              if ({i2cAddr, i2cRdWr, i2cInData} !== b) begin
                miscompares++;
                $display("FAIL beat: addr=%h rdWr=%0b data=%h required addr=%h rdWr=%0b data=%h",
                         i2cAddr, i2cRdWr, i2cInData, b.addr, b.rdwr, b.data);
              end
            end
          end
          if (rspValid) begin
            if (rsp_hold > 0) begin rspReady = 1'b0; rsp_hold--; end
            else rspReady = 1'b1;
          end else rspReady = 1'b0;
          if (rspValid && rspReady) begin
            vectors++;
            rsp_count++;
            if (rsp_q.size() == 0) begin
              miscompares++;
              $display("FAIL rsp_unexpected: err=%0b data=%h required none", rspErr, rspData);
            end else begin
              r = rsp_q.pop_front();
              if ({rspErr, rspData} !== r) begin
                miscompares++;
                $display("FAIL rsp: err=%0b data=%h required err=%0b data=%h", rspErr, rspData, r.err, r.data);
              end
            end
          end
        end
      end
    join_none
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_midreset();
    vectors++;
    if (beat_q.size() != 0 || rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: beats=%0d rsps=%0d required 0/0", beat_q.size(), rsp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
